// File: rtl/shift_reg_pkg.sv
// Shared types for the universal shift register: transfer modes, FSM states
// and serial direction encodings.
package shift_reg_pkg;

   typedef enum logic [1:0] {
      PIPO = 2'b00,
      SIPO = 2'b01,
      PISO = 2'b10,
      SISO = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_e;

   localparam logic MSB_FIRST = 1'b0;
   localparam logic LSB_FIRST = 1'b1;

endpackage

// File: rtl/bit_cnt.sv
// Bit counter framing one serial transfer: synchronous clear, count enable,
// terminal-count flag when the count reaches DW-1.
module bit_cnt #(
   parameter  int DW = 8,
   localparam int CW = $clog2(DW)
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam logic [CW-1:0] TC = CW'(DW - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == TC);

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: PIPO/SIPO/PISO/SISO transfers with per-transfer
// direction, framed by an IDLE/SHIFT/DONE FSM and a bit counter.
module univ_shift_reg
   import shift_reg_pkg::*;
#(
   parameter  int DW = 8,
   localparam int CW = $clog2(DW)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enb,
   input  logic          i_start,
   input  logic [1:0]    i_mode,
   input  logic          i_dir,
   input  logic          i_serial,
   input  logic [DW-1:0] i_data,
   output logic [DW-1:0] o_data,
   output logic          o_serial,
   output logic          o_busy,
   output logic          o_done
);

   state_e        state_q, state_d;
   logic          dir_q, dir_d;
   logic [DW-1:0] data_q, data_d;
   logic          cnt_clr;
   logic          cnt_en;
   logic          cnt_tc;
   logic [DW-1:0] shifted;

   bit_cnt #(
      .DW (DW)
   ) u_bit_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (cnt_clr),
      .en_i  (cnt_en),
      .tc_o  (cnt_tc)
   );

   // i_serial always fills the vacated end, so SIPO/PISO/SISO share one shift path
   assign shifted = (dir_q == MSB_FIRST) ? {data_q[DW-2:0], i_serial}
                                         : {i_serial, data_q[DW-1:1]};

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      data_d  = data_q;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      case (state_q)
         IDLE: begin
            if (enb && i_start) begin
               dir_d   = i_dir;
               cnt_clr = 1'b1;
               // mode only steers the start action, so it needs no register
               case (mode_e'(i_mode))
                  PIPO: begin
                     data_d  = i_data;
                     state_d = DONE;
                  end
                  PISO: begin
                     data_d  = i_data;
                     state_d = SHIFT;
                  end
                  default: state_d = SHIFT;
               endcase
            end
         end
         SHIFT: begin
            if (enb) begin
               data_d = shifted;
               if (cnt_tc) begin
                  state_d = DONE;
               end else begin
                  cnt_en = 1'b1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         dir_q   <= MSB_FIRST;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         data_q  <= data_d;
      end
   end

   assign o_data   = data_q;
   assign o_serial = (dir_q == MSB_FIRST) ? data_q[DW-1] : data_q[0];
   assign o_busy   = (state_q != IDLE);
   assign o_done   = (state_q == DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg (DW=8): abstract model compared every cycle plus
// directed transfers with hand-computed expectations.
module tb_univ_shift_reg;

   logic       clk;
   logic       rst;
   logic       enb;
   logic       i_start;
   logic [1:0] i_mode;
   logic       i_dir;
   logic       i_serial;
   logic [7:0] i_data;
   logic [7:0] o_data;
   logic       o_serial;
   logic       o_busy;
   logic       o_done;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   univ_shift_reg #(.DW(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .enb      (enb),
      .i_start  (i_start),
      .i_mode   (i_mode),
      .i_dir    (i_dir),
      .i_serial (i_serial),
      .i_data   (i_data),
      .o_data   (o_data),
      .o_serial (o_serial),
      .o_busy   (o_busy),
      .o_done   (o_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Abstract model: a byte, a count of shifts still owed, a done flag.
   logic [7:0] m_reg;
   logic       m_dir;
   logic       m_done;
   int         m_left;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_reg  <= 8'h00;
         m_dir  <= 1'b0;
         m_done <= 1'b0;
         m_left <= 0;
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (m_left > 0) begin
         if (enb) begin
            if (m_dir) m_reg <= (m_reg >> 1) | (8'(i_serial) << 7);
            else       m_reg <= (m_reg << 1) | 8'(i_serial);
            m_left <= m_left - 1;
            if (m_left == 1) m_done <= 1'b1;
         end
      end else if (enb && i_start) begin
         m_dir <= i_dir;
         if (i_mode == 2'b00 || i_mode == 2'b10) m_reg <= i_data;
         if (i_mode == 2'b00) m_done <= 1'b1;
         else                 m_left <= 8;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("model_data",   32'(o_data),   32'(m_reg));
         chk("model_serial", 32'(o_serial), 32'(m_dir ? m_reg[0] : m_reg[7]));
         chk("model_busy",   32'(o_busy),   32'(m_done || (m_left > 0)));
         chk("model_done",   32'(o_done),   32'(m_done));
      end
   end

   // One transfer driven at negedges; done_cyc counts cycles from the start
   // edge (first cycle after it = 1); sout records o_serial at each shift, first bit in [7].
   task automatic xfer(input logic [1:0] mode, input logic dir, input logic [7:0] data,
                       input logic [7:0] ser, input int stall_at, input int abort_at,
                       input bit perturb, output int done_cyc, output logic [7:0] sout,
                       output int ndone);
      int shifts;
      int stall_rem;
      bit fin;
      done_cyc  = 0;
      sout      = 8'h00;
      ndone     = 0;
      shifts    = 0;
      stall_rem = 3;
      fin       = 1'b0;
      @(negedge clk);
      i_start = 1'b1;
      i_mode  = mode;
      i_dir   = dir;
      i_data  = data;
      enb     = 1'b1;
      for (int cyc = 1; cyc <= 40 && !fin; cyc++) begin
         @(negedge clk);
         i_start = 1'b0;
         enb     = 1'b1;
         if (o_done) begin
            ndone++;
            if (done_cyc == 0) done_cyc = cyc;
         end
         if (done_cyc != 0 && cyc >= done_cyc + 2) fin = 1'b1;
         if (o_busy && !o_done) begin
            if (shifts == abort_at) begin
               #2 rst = 1'b0;
               #1;
               chk("abort_data",   32'(o_data),   32'h0);
               chk("abort_serial", 32'(o_serial), 32'h0);
               chk("abort_busy",   32'(o_busy),   32'h0);
               chk("abort_done",   32'(o_done),   32'h0);
               @(negedge clk);
               #2 rst = 1'b1;
               return;
            end else if (shifts == stall_at && stall_rem > 0) begin
               enb = 1'b0;
               stall_rem--;
            end else begin
               sout[7-shifts] = o_serial;
               i_serial       = ser[7-shifts];
               shifts++;
            end
            if (perturb && shifts == 3) begin
               i_start = 1'b1;
               i_mode  = 2'b00;
               i_dir   = ~dir;
               i_data  = 8'hFF;
            end
         end
      end
      if (done_cyc == 0) chk("done_timeout", 32'h0, 32'h1);
   endtask

   int         dc;
   int         nd;
   logic [7:0] so;

   initial begin
      rst      = 1'b0;
      enb      = 1'b0;
      i_start  = 1'b0;
      i_mode   = 2'b00;
      i_dir    = 1'b0;
      i_serial = 1'b0;
      i_data   = 8'h00;
      repeat (2) @(negedge clk);
      chk("reset_data", 32'(o_data),   32'h0);
      chk("reset_ser",  32'(o_serial), 32'h0);
      chk("reset_busy", 32'(o_busy),   32'h0);
      chk("reset_done", 32'(o_done),   32'h0);
      cmp_en = 1'b1;
      #2 rst = 1'b1;

      // PIPO load
      xfer(2'b00, 1'b0, 8'hA5, 8'h00, -1, -1, 1'b0, dc, so, nd);
      chk("pipo_data",  32'(o_data), 32'hA5);
      chk("pipo_dcyc",  32'(dc),     32'd1);
      chk("pipo_ndone", 32'(nd),     32'd1);

      // SIPO MSB-first, bits 1,0,1,1,0,0,1,0
      xfer(2'b01, 1'b0, 8'h00, 8'b1011_0010, -1, -1, 1'b0, dc, so, nd);
      chk("sipo_data", 32'(o_data), 32'hB2);
      chk("sipo_dcyc", 32'(dc),     32'd9);

      // PISO LSB-first of 3C
      xfer(2'b10, 1'b1, 8'h3C, 8'h00, -1, -1, 1'b0, dc, so, nd);
      chk("piso_sout", 32'(so), 32'b0011_1100);
      chk("piso_dcyc", 32'(dc), 32'd9);

      // SIPO with three stall cycles after the fourth shift
      xfer(2'b01, 1'b0, 8'h00, 8'b1011_0010, 4, -1, 1'b0, dc, so, nd);
      chk("stall_data", 32'(o_data), 32'hB2);
      chk("stall_dcyc", 32'(dc),     32'd12);

      // PISO aborted by reset after the fourth shift, then a clean PIPO
      xfer(2'b10, 1'b0, 8'h3C, 8'h00, -1, 4, 1'b0, dc, so, nd);
      xfer(2'b00, 1'b1, 8'h5A, 8'h00, -1, -1, 1'b0, dc, so, nd);
      chk("post_rst_data", 32'(o_data), 32'h5A);
      chk("post_rst_dcyc", 32'(dc),     32'd1);

      // start/mode/dir/data disturbed mid-transfer must be ignored
      xfer(2'b10, 1'b1, 8'h3C, 8'h00, -1, -1, 1'b1, dc, so, nd);
      chk("perturb_sout",  32'(so),     32'b0011_1100);
      chk("perturb_ndone", 32'(nd),     32'd1);
      chk("perturb_dcyc",  32'(dc),     32'd9);
      chk("perturb_data",  32'(o_data), 32'h00);

      // SISO delay line: old C3 leaves MSB-first while 5A enters
      xfer(2'b00, 1'b0, 8'hC3, 8'h00, -1, -1, 1'b0, dc, so, nd);
      xfer(2'b11, 1'b0, 8'hFF, 8'h5A, -1, -1, 1'b0, dc, so, nd);
      chk("siso_sout", 32'(so),     32'hC3);
      chk("siso_data", 32'(o_data), 32'h5A);

      repeat (2) @(negedge clk);
      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
